if_stage_fetch: RTL and testbench
=================================

# if_stage_fetch

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined CPU. Holds the PC, drives the instruction-memory address, selects the next PC among sequential, jump, taken-bne and jr targets, and registers fetched instruction plus PC+4 into IF/ID. Sits directly upstream of the flush/discard logic: consumes `IF_flush` to replace the IF/ID contents with a bubble, and the `stall` from the hazard unit to freeze fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP`, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0)
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold PC and IF/ID (load-use hazard)
- `IF_flush`  in  1  discard instruction being fetched (OR of jump/bne/jr)
- `jump`  in  1  j/jal resolved in ID
- `jump_addr`  in  32  jump target
- `bne`  in  1  taken bne resolved in EX
- `branch_addr`  in  32  branch target
- `jr`  in  1  jr resolved in EX
- `jr_addr`  in  32  register target
- `imem_addr`  out  32  current PC, to instruction memory (combinational read)
- `imem_rdata`  in  32  instruction at `imem_addr`, same cycle
- `IF_ID_pc4`  out  32  registered PC+4 of instruction in ID
- `IF_ID_instr`  out  32  registered instruction in ID
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble

## Operation
- Next-PC priority: `jr` > `bne` > `jump` > PC+4 (older instruction's redirect wins).
- Redirect (any of jr/bne/jump) overrides `stall`: PC loads target, IF/ID loads bubble.
- `IF_flush`=1: IF/ID loads `NOP`, pc4 0, valid 0, regardless of `stall`.
- `stall`=1 and no flush/redirect: PC, IF/ID all hold.
- Otherwise: PC <= PC+4; IF/ID <= {`imem_rdata`, PC+4, valid=1}.
- `IF_flush` without any redirect input: bubble inserted, PC advances normally (legal, defensive).
- Redirect without `IF_flush`: PC redirected, IF/ID loads fetched word (caller's contract to assert both; not checked).
- PC+4 arithmetic modulo 2^32; 32'hFFFF_FFFC wraps to 0. Targets taken as-is, low 2 bits not masked.

## Timing
- Reset (async assert, sync-free deassert): PC = `RESET_PC`, `IF_ID_instr` = `NOP`, `IF_ID_pc4` = 0, `IF_ID_valid` = 0, counters 0.
- First edge after deassert: IF/ID captures word at `RESET_PC`; valid=1 one cycle after reset release.
- Fetch-to-ID latency: 1 cycle. Redirect-to-fetch of target: same edge updates PC; target instruction in IF/ID one cycle later.
- Reset asserted mid-operation clears state immediately, no pending redirect retained.

## Configuration
- `IF_PERF_CNT_EN` defined: adds outputs `flush_cnt`[31:0] (edges with `IF_flush`=1) and `stall_cnt`[31:0] (edges with `stall`=1 and no redirect); both saturate at 32'hFFFF_FFFF, reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared `cpu_pkg`: `NOP` instruction constant, `RESET_PC` default, 2-bit next-PC-source encoding (SEQ, JUMP, BNE, JR).
- Sub-module `pc_next_sel`: combinational priority mux producing next PC and source code; top holds PC, IF/ID registers and counters.

## Test plan
- Reset with `RESET_PC`=0x100, release, imem returns 0x1111_0000+addr -> `imem_addr` 0x100, 0x104, 0x108; IF_ID_instr 0x1111_0100 with pc4 0x104, valid 1.
- `stall` 2 cycles at PC 0x108 -> PC and IF/ID unchanged for 2 edges, resume at 0x10C.
- `jump`+`IF_flush`, `jump_addr`=0x400 -> next edge PC=0x400, IF_ID_valid 0, instr `NOP`; following edge instr from 0x400.
- `jr`(0x800), `bne`(0x600), `jump`(0x400) together with `IF_flush` and `stall` -> PC=0x800, bubble in IF/ID.
- PC at 0xFFFF_FFFC, no stall -> PC wraps to 0x0, IF_ID_pc4 0x0.
- With `IF_PERF_CNT_EN`: 3 flushes, 2 stalls -> flush_cnt 3, stall_cnt 2; force counter to 0xFFFF_FFFF, flush -> stays 0xFFFF_FFFF; assert `rst_n` low mid-run -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default reset PC, next-PC source codes.
package cpu_pkg;

   localparam logic [31:0] CPU_NOP      = 32'h0000_0000;
   localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SRC_SEQ  = 2'd0,
      PC_SRC_JUMP = 2'd1,
      PC_SRC_BNE  = 2'd2,
      PC_SRC_JR   = 2'd3
   } pc_src_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_stage_fetch_pc_next_sel.sv
// Next-PC priority mux: jr > bne > jump > sequential; the older instruction's redirect wins.
module pc_next_sel
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        bne,
   input  logic [31:0] branch_addr,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] next_pc,
   output pc_src_e     pc_src
);

   // priority selection of the next fetch address
   always_comb begin
      next_pc = pc_plus4(pc);
      pc_src  = PC_SRC_SEQ;
      if (jr) begin
         next_pc = jr_addr;
         pc_src  = PC_SRC_JR;
      end else if (bne) begin
         next_pc = branch_addr;
         pc_src  = PC_SRC_BNE;
      end else if (jump) begin
         next_pc = jump_addr;
         pc_src  = PC_SRC_JUMP;
      end else begin
         next_pc = pc_plus4(pc);
         pc_src  = PC_SRC_SEQ;
      end
   end

endmodule

// File: rtl/if_stage_fetch.sv
// Fetch stage: PC register, imem address, IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds saturating flush/stall event counters.
module if_stage_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC,
   parameter logic [31:0] NOP      = CPU_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        IF_flush,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        bne,
   input  logic [31:0] branch_addr,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_pc4,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] flush_cnt,
   output logic [31:0] stall_cnt
`endif
);

   logic [31:0] pc_r;
   logic [31:0] next_pc_s;
   pc_src_e     pc_src_s;
   logic        redirect_s;

   pc_next_sel u_pc_next_sel (
      .pc          (pc_r),
      .jump        (jump),
      .jump_addr   (jump_addr),
      .bne         (bne),
      .branch_addr (branch_addr),
      .jr          (jr),
      .jr_addr     (jr_addr),
      .next_pc     (next_pc_s),
      .pc_src      (pc_src_s)
   );

   assign redirect_s = (pc_src_s != PC_SRC_SEQ);
   assign imem_addr  = pc_r;

   // PC register: a redirect always loads, otherwise advance unless stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else if (redirect_s || !stall) begin
         pc_r <= next_pc_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   // IF/ID register: flush wins, a redirect punches through stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         IF_ID_instr <= NOP;
         IF_ID_pc4   <= 32'h0000_0000;
         IF_ID_valid <= 1'b0;
      end else if (IF_flush) begin
         IF_ID_instr <= NOP;
         IF_ID_pc4   <= 32'h0000_0000;
         IF_ID_valid <= 1'b0;
      end else if (redirect_s || !stall) begin
         IF_ID_instr <= imem_rdata;
         IF_ID_pc4   <= pc_plus4(pc_r);
         IF_ID_valid <= 1'b1;
      end else begin
         IF_ID_instr <= IF_ID_instr;
         IF_ID_pc4   <= IF_ID_pc4;
         IF_ID_valid <= IF_ID_valid;
      end
   end

`ifdef IF_PERF_CNT_EN
   // saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= 32'h0000_0000;
         stall_cnt <= 32'h0000_0000;
      end else begin
         if (IF_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end else begin
            flush_cnt <= flush_cnt;
         end
         if (stall && !redirect_s && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch; counter tests compile in with IF_PERF_CNT_EN.
module tb_if_stage_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, IF_flush, jump, bne, jr;
   logic [31:0] jump_addr, branch_addr, jr_addr;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] IF_ID_pc4, IF_ID_instr;
   logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] flush_cnt, stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   exp_t q[$];

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] m_fcnt, m_scnt;

   always #5 clk = ~clk;

   assign imem_rdata = 32'h1111_0000 + imem_addr;

   if_stage_fetch #(.RESET_PC(32'h0000_0100), .NOP(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .IF_flush(IF_flush),
      .jump(jump), .jump_addr(jump_addr), .bne(bne), .branch_addr(branch_addr),
      .jr(jr), .jr_addr(jr_addr), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .IF_ID_pc4(IF_ID_pc4), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
`ifdef IF_PERF_CNT_EN
      , .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
   );

   task automatic model_reset();
      m_pc = 32'h0000_0100; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fcnt = 32'h0; m_scnt = 32'h0;
      q.delete();
   endtask

   task automatic idle_inputs();
      stall = 1'b0; IF_flush = 1'b0; jump = 1'b0; bne = 1'b0; jr = 1'b0;
      jump_addr = 32'h0; branch_addr = 32'h0; jr_addr = 32'h0;
   endtask

   // advance one edge: model predicts, scoreboard compares after the edge
   task automatic cycle();
      exp_t e, got;
      logic redir;
      logic [31:0] tgt;
      redir = jr | bne | jump;
      tgt = jr ? jr_addr : bne ? branch_addr : jump ? jump_addr : m_pc + 32'd4;
      if (IF_flush) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (redir || !stall) begin
         m_instr = 32'h1111_0000 + m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (IF_flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
      if (stall && !redir && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      if (redir || !stall) m_pc = tgt;
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
      q.push_back(e);
      @(posedge clk);
      #1;
      got = q.pop_front();
      checks++;
      if (imem_addr !== got.pc) begin
         errors++; $display("FAIL pc: got %h expected %h", imem_addr, got.pc);
      end
      checks++;
      if (IF_ID_instr !== got.instr) begin
         errors++; $display("FAIL instr: got %h expected %h", IF_ID_instr, got.instr);
      end
      checks++;
      if (IF_ID_pc4 !== got.pc4) begin
         errors++; $display("FAIL pc4: got %h expected %h", IF_ID_pc4, got.pc4);
      end
      checks++;
      if (IF_ID_valid !== got.valid) begin
         errors++; $display("FAIL valid: got %b expected %b", IF_ID_valid, got.valid);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (imem_addr !== 32'h0000_0100 || IF_ID_instr !== 32'h0 ||
          IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s: got pc %h instr %h pc4 %h valid %b expected 100/0/0/0",
                  tag, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cycle();
      checks++;
      if (IF_ID_instr !== 32'h1111_0100 || IF_ID_pc4 !== 32'h0000_0104 || IF_ID_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_fetch: got %h/%h/%b expected 11110100/00000104/1",
                  IF_ID_instr, IF_ID_pc4, IF_ID_valid);
      end
      cycle();
   endtask

   task automatic test_stall();
      checks++;
      if (imem_addr !== 32'h0000_0108) begin
         errors++; $display("FAIL stall_start: got %h expected 00000108", imem_addr);
      end
      stall = 1'b1;
      cycle();
      cycle();
      stall = 1'b0;
      cycle();
      checks++;
      if (imem_addr !== 32'h0000_010C) begin
         errors++; $display("FAIL stall_resume: got %h expected 0000010c", imem_addr);
      end
   endtask

   task automatic test_jump();
      jump = 1'b1; jump_addr = 32'h0000_0400; IF_flush = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (imem_addr !== 32'h0000_0400 || IF_ID_valid !== 1'b0) begin
         errors++; $display("FAIL jump: got pc %h valid %b expected 00000400 0", imem_addr, IF_ID_valid);
      end
      cycle();
      checks++;
      if (IF_ID_instr !== 32'h1111_0400) begin
         errors++; $display("FAIL jump_target: got %h expected 11110400", IF_ID_instr);
      end
      cycle();
   endtask

   task automatic test_priority();
      jr = 1'b1; jr_addr = 32'h0000_0800;
      bne = 1'b1; branch_addr = 32'h0000_0600;
      jump = 1'b1; jump_addr = 32'h0000_0400;
      IF_flush = 1'b1; stall = 1'b1;
      cycle();
      checks++;
      if (imem_addr !== 32'h0000_0800) begin
         errors++; $display("FAIL prio_jr: got %h expected 00000800", imem_addr);
      end
      jr = 1'b0;
      cycle();
      jump = 1'b0; IF_flush = 1'b0;
      cycle();
      bne = 1'b0; stall = 1'b0;
      IF_flush = 1'b1;
      cycle();
      IF_flush = 1'b0; jump = 1'b1; jump_addr = 32'h0000_0A02;
      cycle();
      idle_inputs();
      stall = 1'b1; IF_flush = 1'b1;
      cycle();
      idle_inputs();
      cycle();
   endtask

   task automatic test_wrap();
      jump = 1'b1; jump_addr = 32'hFFFF_FFFC; IF_flush = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      checks++;
      if (imem_addr !== 32'h0 || IF_ID_pc4 !== 32'h0) begin
         errors++; $display("FAIL wrap: got pc %h pc4 %h expected 0 0", imem_addr, IF_ID_pc4);
      end
      cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         stall = 1'($urandom_range(0, 3) == 0);
         jump = 1'($urandom_range(0, 7) == 0);
         bne = 1'($urandom_range(0, 7) == 0);
         jr = 1'($urandom_range(0, 9) == 0);
         jump_addr = $urandom & 32'h0000_FFFC;
         branch_addr = $urandom;
         jr_addr = $urandom;
         IF_flush = jump | bne | jr | 1'($urandom_range(0, 9) == 0);
         cycle();
      end
      idle_inputs();
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf();
      logic [31:0] f0, s0;
      f0 = m_fcnt; s0 = m_scnt;
      checks++;
      if (flush_cnt !== m_fcnt || stall_cnt !== m_scnt) begin
         errors++; $display("FAIL cnt_running: got %h/%h expected %h/%h", flush_cnt, stall_cnt, m_fcnt, m_scnt);
      end
      for (int i = 0; i < 3; i++) begin
         IF_flush = 1'b1; cycle();
      end
      IF_flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         stall = 1'b1; cycle();
      end
      stall = 1'b0;
      checks++;
      if (flush_cnt !== f0 + 32'd3 || stall_cnt !== s0 + 32'd2) begin
         errors++; $display("FAIL cnt_delta: got %h/%h expected %h/%h", flush_cnt, stall_cnt, f0 + 32'd3, s0 + 32'd2);
      end
      force dut.flush_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.flush_cnt;
      m_fcnt = 32'hFFFF_FFFF;
      IF_flush = 1'b1; cycle(); IF_flush = 1'b0;
      checks++;
      if (flush_cnt !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL cnt_sat: got %h expected ffffffff", flush_cnt);
      end
   endtask
`endif

   task automatic test_async_reset();
      jump = 1'b1; jump_addr = 32'h0000_0C00; IF_flush = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
`ifdef IF_PERF_CNT_EN
      checks++;
      if (flush_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
         errors++; $display("FAIL cnt_reset: got %h/%h expected 0/0", flush_cnt, stall_cnt);
      end
`endif
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cycle();
      checks++;
      if (IF_ID_instr !== 32'h1111_0100 || imem_addr !== 32'h0000_0104) begin
         errors++; $display("FAIL post_reset: got %h/%h expected 11110100/00000104", IF_ID_instr, imem_addr);
      end
   endtask

   initial begin
      fork
         begin
            #200000;
            $display("FAIL timeout: got no finish expected finish");
            $fatal(1);
         end
      join_none
      test_reset();
      test_stall();
      test_jump();
      test_priority();
      test_wrap();
      test_random();
`ifdef IF_PERF_CNT_EN
      test_perf();
`endif
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
